fft_load_ctrl: RTL and testbench

//  Frame-load sequencer for the FFT front end. Accepts a valid/ready sample stream and drives the

---
 rtl/fft_pkg.sv | 14 +
 rtl/fft_load_ctrl.sv | 117 +++++++++++
 tb/tb_fft_load_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT front-end frame loader.
package fft_pkg;

   localparam int FFT_N_SAMPLES = 128;
   localparam int FFT_DATA_W    = 8;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      SETTLE = 2'd1,
      START  = 2'd2,
      WAIT   = 2'd3
   } fft_load_state_t;

endpackage

// File: rtl/fft_load_ctrl.sv
// Frame-load sequencer: streams N_SAMPLES samples into the loading buffer, pulses frame_start,
// then waits for fft_done. Optional overrun counter enabled by defining OVERRUN_CNT_EN.
//
// state  | meaning
// LOAD   | accepting samples, shifting them into the buffer
// SETTLE | last shift_in is on the buffer pins
// START  | frame_start pulse to the FFT core
// WAIT   | holding off input until fft_done
module fft_load_ctrl
   import fft_pkg::*;
#(
   parameter int N_SAMPLES = FFT_N_SAMPLES,
   parameter int DATA_W    = FFT_DATA_W,
   parameter int CNT_W     = $clog2(N_SAMPLES) + 1
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   output logic              sample_ready,
   input  logic              abort,
   output logic              shift_in,
   output logic [DATA_W-1:0] data_out,
   output logic              frame_start,
   input  logic              fft_done,
   output logic              busy,
   output logic [CNT_W-1:0]  sample_cnt
`ifdef OVERRUN_CNT_EN
   ,
   output logic [15:0]       overrun_cnt
`endif
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

   fft_load_state_t   r_state;
   fft_load_state_t   w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_shift;
   logic [DATA_W-1:0] r_data;
   logic              w_accept;

   assign w_accept = sample_valid && sample_ready;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (abort) begin
         w_state_nxt = LOAD;
      end else begin
         case (r_state)
            LOAD:    if (w_accept && (r_cnt == CNT_LAST)) w_state_nxt = SETTLE;
            SETTLE:  w_state_nxt = START;
            START:   w_state_nxt = WAIT;
            WAIT:    if (fft_done) w_state_nxt = LOAD;
            default: w_state_nxt = LOAD;
         endcase
      end
   end

   always_comb begin
      sample_ready = (r_state == LOAD) && !abort;
      busy         = (r_state != LOAD);
      frame_start  = (r_state == START);
   end

   // Cleared on abort and on leaving WAIT so a new frame always starts at zero.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_cnt <= '0;
      end else if (abort || ((r_state == WAIT) && fft_done)) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

   // Accept is already gated by abort, so an aborted sample never reaches the buffer.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_shift <= 1'b0;
         r_data  <= '0;
      end else begin
         r_shift <= w_accept;
         if (w_accept) begin
            r_data <= sample_in;
         end
      end
   end

   assign shift_in   = r_shift;
   assign data_out   = r_data;
   assign sample_cnt = r_cnt;

`ifdef OVERRUN_CNT_EN
   logic [15:0] r_overrun;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_overrun <= '0;
      end else if (sample_valid && !sample_ready && (r_overrun != 16'hFFFF)) begin
         r_overrun <= r_overrun + 16'd1;
      end
   end

   assign overrun_cnt = r_overrun;
`endif

endmodule

// File: tb/tb_fft_load_ctrl.sv
// Directed bench for fft_load_ctrl: segment table plus hand sequences; overrun checks need OVERRUN_CNT_EN.
module tb_fft_load_ctrl;
   import fft_pkg::*;

   localparam int N  = FFT_N_SAMPLES;
   localparam int DW = FFT_DATA_W;
   localparam int CW = $clog2(N) + 1;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic [DW-1:0] sample_in = '0;
   logic          sample_valid = 1'b0;
   logic          abort = 1'b0;
   logic          fft_done = 1'b0;
   logic          sample_ready;
   logic          shift_in;
   logic [DW-1:0] data_out;
   logic          frame_start;
   logic          busy;
   logic [CW-1:0] sample_cnt;
`ifdef OVERRUN_CNT_EN
   logic [15:0]   overrun_cnt;
`endif

   fft_load_ctrl dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .abort        (abort),
      .shift_in     (shift_in),
      .data_out     (data_out),
      .frame_start  (frame_start),
      .fft_done     (fft_done),
      .busy         (busy),
      .sample_cnt   (sample_cnt)
`ifdef OVERRUN_CNT_EN
      ,
      .overrun_cnt  (overrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    cycles;
      bit    valid;
      bit    toggle;
      bit    abrt;
      bit    done;
      int    exp_shifts;
      int    exp_starts;
      int    exp_cnt;
      bit    exp_busy;
   } seg_t;

   int            n_pass = 0;
   int            n_total = 0;
   int            n_shift;
   int            n_start;
   int            n_derr;
   logic [DW-1:0] prev_in;
   logic [DW-1:0] seq_val = 8'h10;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // One clock; afterwards count shifts/pulses and verify data_out carries the prior cycle's sample.
   task automatic tick();
      prev_in = sample_in;
      @(posedge clk);
      #1;
      if (shift_in === 1'b1) begin
         n_shift++;
         if (data_out !== prev_in) n_derr++;
      end
      if (frame_start === 1'b1) n_start++;
   endtask

   task automatic idle_inputs();
      sample_valid = 1'b0;
      abort        = 1'b0;
      fft_done     = 1'b0;
   endtask

   seg_t segs [13];

   initial begin
      int e_sh, e_rd, e_bz, e_fs, e_ct;
      int exp_c;

      segs[0]  = '{"idle",          3,   1'b0, 1'b0, 1'b0, 1'b0, 0,   0, 0,   1'b0};
      segs[1]  = '{"cont_frame",    128, 1'b1, 1'b0, 1'b0, 1'b0, 128, 0, 128, 1'b1};
      segs[2]  = '{"to_wait",       4,   1'b0, 1'b0, 1'b0, 1'b0, 0,   1, 128, 1'b1};
      segs[3]  = '{"done_in_wait",  1,   1'b0, 1'b0, 1'b0, 1'b1, 0,   0, 0,   1'b0};
      segs[4]  = '{"toggle_frame",  256, 1'b0, 1'b1, 1'b0, 1'b0, 128, 1, 128, 1'b1};
      segs[5]  = '{"done_from_st",  2,   1'b0, 1'b0, 1'b0, 1'b1, 0,   0, 0,   1'b0};
      segs[6]  = '{"abort_idle",    2,   1'b1, 1'b0, 1'b1, 1'b0, 0,   0, 0,   1'b0};
      segs[7]  = '{"done_in_load",  2,   1'b0, 1'b0, 1'b0, 1'b1, 0,   0, 0,   1'b0};
      segs[8]  = '{"partial_60",    60,  1'b1, 1'b0, 1'b0, 1'b0, 60,  0, 60,  1'b0};
      segs[9]  = '{"abort_at_60",   1,   1'b1, 1'b0, 1'b1, 1'b0, 0,   0, 0,   1'b0};
      segs[10] = '{"refill",        128, 1'b1, 1'b0, 1'b0, 1'b0, 128, 0, 128, 1'b1};
      segs[11] = '{"valid_in_wait", 3,   1'b1, 1'b0, 1'b0, 1'b0, 0,   1, 128, 1'b1};
      segs[12] = '{"abort_wait",    1,   1'b0, 1'b0, 1'b1, 1'b0, 0,   0, 0,   1'b0};

      // Reset values
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check("rst_shift_in",    int'(shift_in),    0);
      check("rst_data_out",    int'(data_out),    0);
      check("rst_frame_start", int'(frame_start), 0);
      check("rst_busy",        int'(busy),        0);
      check("rst_sample_cnt",  int'(sample_cnt),  0);
`ifdef OVERRUN_CNT_EN
      check("rst_overrun_cnt", int'(overrun_cnt), 0);
`endif
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      check("rel_ready", int'(sample_ready), 1);
      check("rel_busy",  int'(busy),         0);

      // Segment table: state carries over from one record to the next
      for (int s = 0; s < 13; s++) begin
         n_shift = 0;
         n_start = 0;
         n_derr  = 0;
         for (int c = 0; c < segs[s].cycles; c++) begin
            sample_valid = segs[s].toggle ? (c % 2 == 0) : segs[s].valid;
            abort        = segs[s].abrt;
            fft_done     = segs[s].done;
            sample_in    = seq_val;
            seq_val      = seq_val + 8'd1;
            tick();
         end
         idle_inputs();
         #1;
         check({segs[s].name, "_shifts"}, n_shift,          segs[s].exp_shifts);
         check({segs[s].name, "_starts"}, n_start,          segs[s].exp_starts);
         check({segs[s].name, "_cnt"},    int'(sample_cnt), segs[s].exp_cnt);
         check({segs[s].name, "_busy"},   int'(busy),       int'(segs[s].exp_busy));
         check({segs[s].name, "_ready"},  int'(sample_ready), int'(!segs[s].exp_busy));
         check({segs[s].name, "_data"},   n_derr,           0);
      end

      // Cycle-exact frame: first accept before edge 1, fft_done during START then 5 cycles into WAIT
      e_sh = 0; e_rd = 0; e_bz = 0; e_fs = 0; e_ct = 0;
      n_shift = 0; n_start = 0; n_derr = 0;
      for (int e = 1; e <= 136; e++) begin
         sample_valid = (e <= 128);
         sample_in    = (e <= 128) ? DW'(e - 1) : 8'hAA;
         fft_done     = (e == 130) || (e == 135);
         tick();
         exp_c = (e <= 128) ? e : ((e < 135) ? 128 : 0);
         if (shift_in    !== (e <= 128))               e_sh++;
         if (sample_ready !== ((e < 128) || (e >= 135))) e_rd++;
         if (busy        !== ((e >= 128) && (e < 135))) e_bz++;
         if (frame_start !== (e == 129))                e_fs++;
         if (sample_cnt  !== CW'(exp_c))                e_ct++;
      end
      idle_inputs();
      check("seq_shift_timing", e_sh,    0);
      check("seq_ready_timing", e_rd,    0);
      check("seq_busy_timing",  e_bz,    0);
      check("seq_start_timing", e_fs,    0);
      check("seq_cnt_timing",   e_ct,    0);
      check("seq_shift_total",  n_shift, 128);
      check("seq_data_order",   n_derr,  0);

      // Asynchronous reset in the middle of a frame
      for (int k = 0; k < 90; k++) begin
         sample_valid = 1'b1;
         sample_in    = DW'(k + 7);
         tick();
      end
      check("mid_cnt_before", int'(sample_cnt), 90);
      #3;
      n_rst = 1'b0;
      #1;
      check("mid_rst_cnt",   int'(sample_cnt), 0);
      check("mid_rst_shift", int'(shift_in),   0);
      check("mid_rst_data",  int'(data_out),   0);
      check("mid_rst_busy",  int'(busy),       0);
      idle_inputs();
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rel_ready", int'(sample_ready), 1);

`ifdef OVERRUN_CNT_EN
      for (int k = 0; k < N; k++) begin
         sample_valid = 1'b1;
         sample_in    = DW'(k);
         tick();
      end
      sample_valid = 1'b0;
      tick();
      tick();
      check("ovr_zero_before_wait", int'(overrun_cnt), 0);
      sample_valid = 1'b1;
      repeat (10) tick();
      check("ovr_ten_in_wait", int'(overrun_cnt), 10);
      sample_valid = 1'b0;
      abort        = 1'b1;
      tick();
      idle_inputs();
      #1;
      check("ovr_abort_keeps", int'(overrun_cnt), 10);
      check("ovr_abort_load",  int'(busy),        0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
